zx_tape_loader: RTL
===================

// Module: zx_tape_loader
// PURPOSE
// - Fast tape-load controller for the ZX80/ZX81 core: buffers a host-downloaded .o/.p image, detects CPU entry to the ROM LOAD routine, then overrides it.
// - While the CPU is in the LOAD routine, supplies a 7-byte patch loop on the opcode bus and schedules buffer-to-main-RAM copy writes; releases the CPU when done.
// - Sits between hps_io ioctl, the T80 bus decode and the main-RAM write port; owns RAM-port arbitration during a load.
// PARAMETERS
// - TAPE_AW   14  tape buffer address width (buffer = 2**TAPE_AW bytes)
// PORTS
// - clk_sys         in   1   system clock
// - reset_n         in   1   asynchronous reset, active low
// - ce_cpu_p        in   1   CPU positive clock enable; one copy step per pulse
// - zx81            in   1   1 = ZX81 ROM map, 0 = ZX80 ROM map
// - nM1             in   1   CPU M1, active low
// - addr            in   16  CPU address bus
// - ioctl_download  in   1   host download in progress
// - ioctl_wr        in   1   host byte strobe
// - ioctl_index     in   8   file index; 0 = ROM (ignored), bits[7:6]!=0 = .p, else .o
// - ioctl_addr      in   25  host byte address
// - ioctl_dout      in   8   host byte
// - tape_ready      out  1   image held in buffer
// - loader_active   out  1   patch owns CPU reads in hook range
// - patch_dout      out  8   patch byte for addr (FF outside hook..hook+6)
// - ram_we          out  1   one-cycle main-RAM write strobe
// - ram_a           out  16  main-RAM write address
// - ram_din         out  8   main-RAM write data
// - tape_sum        out  8   running byte sum of copied data (TAPE_SUM_EN only)
// BEHAVIOUR
// - Reset values: all outputs 0 except patch_dout=FF; FSM=EMPTY, counters 0, len 0.
// - HOOK = zx81 ? 0347h : 0207h; EXIT = zx81 ? 03C3h : 024Dh; JP target low byte = zx81 ? 07h : 03h.
// - Buffer write: ioctl_wr & ioctl_index!=0 & ioctl_addr<2**TAPE_AW -> buf[ioctl_addr]<=ioctl_dout; higher addresses dropped.
// - len = min(max written ioctl_addr+1, 2**TAPE_AW); cleared at download rise; p_fmt latched at download fall.
// - M1 edge = nM1 low this cycle, high last cycle (registered history).
// - FSM states:
//   EMPTY: download fall with index!=0 & len!=0 -> READY; len==0 stays EMPTY.
//   READY: tape_ready=1. M1 edge at addr==HOOK -> COPY; rd_ptr=0, loader_active=1.
//   COPY: patch byte1=00 (NOP loop). Each ce_cpu_p with rd_ptr!=len: issue buf read; 1 cycle later
//     ram_we=1, ram_din=byte, ram_a={2'b01,14-bit (p_fmt ? rd_ptr+9 : rd_ptr)}; rd_ptr++. rd_ptr==len, no write pending -> DONE.
//   DONE: patch byte1=37h (SCF); CPU falls through to JP. Stays until exit.
//   COPY/DONE: M1 edge with addr<HOOK or addr>=EXIT -> READY, loader_active=0 (same cycle as edge +1).
// - Patch ROM: {AF, 00|37, 30, FD, C3, 07|03, 02}; patch_dout=patch[addr-HOOK] when loader_active & offset 0..6.
// - Image stays loaded: re-entering HOOK reloads from rd_ptr=0 (repeatable LOAD).
// - Download rise in any state -> EMPTY next cycle; pending write squashed (ram_we=0); loader_active=0.
// - ram_we never asserted outside COPY; max one write per ce_cpu_p period; rd_ptr never exceeds len.
// - p_fmt address wraps mod 2**14 within 4000h-7FFFh.
// - Same-cycle M1 edge at HOOK and download fall: download wins, no COPY entry.
// - Reset mid-copy: immediate abort, buffer contents undefined-but-retained, tape_ready=0.
// CONFIGURATION
// - TAPE_SUM_EN defined: tape_sum cleared on COPY entry, += ram_din on every ram_we (mod 256); held otherwise.
// - TAPE_SUM_EN undefined: tape_sum tied 0, adder omitted.
// TESTING
// - Download 4 bytes {11,22,33,44} idx=01h (.o), zx81=1; M1 at 0347h -> 4 ram_we at 4000h..4003h in order, then DONE, patch[1]=37h.
// - Same image, idx=41h (.p) -> writes at 4009h..400Ch; addr 034Ch reads patch_dout=07h.
// - zx81=0, M1 at 0207h -> COPY; addr 020Bh reads C3h, 020Ch reads 03h; M1 at 024Dh -> READY, loader_active=0.
// - Download asserted during COPY after 2 writes -> ram_we stays 0, state EMPTY, tape_ready=0 next cycle.
// - Download of 16385 bytes, TAPE_AW=14 -> len=16384, last write ram_a=7FFFh, no 16385th write.
// - TAPE_SUM_EN: bytes {FF,02} -> tape_sum=01h after copy; reset_n low mid-copy -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/zx_tape_loader.sv
// rtl/zx_tape_loader.sv - ZX80/ZX81 fast tape loader: image buffer, LOAD hook patch, RAM copy (option: TAPE_SUM_EN)
module zx_tape_loader #(
   parameter int TAPE_AW = 14
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ce_cpu_p,
   input  logic        zx81,
   input  logic        nM1,
   input  logic [15:0] addr,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [7:0]  ioctl_index,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        tape_ready,
   output logic        loader_active,
   output logic [7:0]  patch_dout,
   output logic        ram_we,
   output logic [15:0] ram_a,
   output logic [7:0]  ram_din,
   output logic [7:0]  tape_sum
);

   localparam int BUF_SIZE = 1 << TAPE_AW;
   localparam logic [TAPE_AW:0] LEN_MAX = {1'b1, {TAPE_AW{1'b0}}};

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_READY = 2'd1;
   localparam logic [1:0] ST_COPY  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [7:0]       tape_mem [BUF_SIZE];
   logic [7:0]       rd_data_q;

   logic [1:0]       state_q, state_d;
   logic             dl_q, nm1_q;
   logic             p_fmt_q, p_fmt_d;
   logic [TAPE_AW:0] len_q, len_d;
   logic [TAPE_AW:0] rd_ptr_q, rd_ptr_d;
   logic             pend_q, pend_d;
   logic [15:0]      ram_a_q, ram_a_d;

   logic             dl_rise, dl_fall, m1_edge, img_wr, buf_wr, issue, exit_hit;
   logic [15:0]      hook_addr, exit_addr, patch_ofs;
   logic [TAPE_AW:0] wr_len;
   logic [13:0]      copy_ofs;

   assign dl_rise   = ioctl_download & ~dl_q;
   assign dl_fall   = ~ioctl_download & dl_q;
   assign m1_edge   = ~nM1 & nm1_q;
   assign hook_addr = zx81 ? 16'h0347 : 16'h0207;
   assign exit_addr = zx81 ? 16'h03C3 : 16'h024D;
   assign exit_hit  = m1_edge & ((addr < hook_addr) | (addr >= exit_addr));
   assign img_wr    = ioctl_wr & (ioctl_index != 8'h00);
   assign buf_wr    = img_wr & (ioctl_addr < 25'(BUF_SIZE));
   // Bytes beyond the buffer still count toward length, capped at the buffer size.
   assign wr_len    = buf_wr ? ({1'b0, ioctl_addr[TAPE_AW-1:0]} + 1'b1) : LEN_MAX;
   assign issue     = (state_q == ST_COPY) & ce_cpu_p & (rd_ptr_q != len_q);
   // .p images skip the 9 system-variable bytes the ROM would not reload; wraps inside 4000h-7FFFh.
   assign copy_ofs  = 14'(rd_ptr_q) + (p_fmt_q ? 14'd9 : 14'd0);

   // Next-state logic: download tracking, hook/exit detection and copy sequencing
   always_comb begin
      state_d  = state_q;
      p_fmt_d  = p_fmt_q;
      len_d    = len_q;
      rd_ptr_d = rd_ptr_q;
      pend_d   = 1'b0;
      ram_a_d  = ram_a_q;
      if (dl_fall) p_fmt_d = |ioctl_index[7:6];
      if (img_wr && (wr_len > len_q)) len_d = wr_len;
      case (state_q)
         ST_EMPTY: if (dl_fall && (ioctl_index != 8'h00) && (len_q != '0)) state_d = ST_READY;
         ST_READY: if (m1_edge && (addr == hook_addr)) begin
            state_d  = ST_COPY;
            rd_ptr_d = '0;
         end
         ST_COPY: begin
            if (issue) begin
               pend_d   = 1'b1;
               rd_ptr_d = rd_ptr_q + 1'b1;
               ram_a_d  = {2'b01, copy_ofs};
            end else if ((rd_ptr_q == len_q) && !pend_q) begin
               state_d = ST_DONE;
            end
            if (exit_hit) begin
               state_d = ST_READY;
               pend_d  = 1'b0;
            end
         end
         default: if (exit_hit) state_d = ST_READY;
      endcase
      // A new download discards the current image and anything in flight.
      if (dl_rise) begin
         state_d = ST_EMPTY;
         len_d   = '0;
         pend_d  = 1'b0;
      end
   end

   // Control state registers
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_EMPTY;
         dl_q     <= 1'b0;
         nm1_q    <= 1'b1;
         p_fmt_q  <= 1'b0;
         len_q    <= '0;
         rd_ptr_q <= '0;
         pend_q   <= 1'b0;
         ram_a_q  <= 16'h0000;
      end else begin
         state_q  <= state_d;
         dl_q     <= ioctl_download;
         nm1_q    <= nM1;
         p_fmt_q  <= p_fmt_d;
         len_q    <= len_d;
         rd_ptr_q <= rd_ptr_d;
         pend_q   <= pend_d;
         ram_a_q  <= ram_a_d;
      end
   end

   // Tape buffer write port; contents survive reset
   always_ff @(posedge clk_sys) begin
      if (buf_wr) tape_mem[ioctl_addr[TAPE_AW-1:0]] <= ioctl_dout;
   end

   // Tape buffer read port, one read per copy step
   always_ff @(posedge clk_sys) begin
      if (issue) rd_data_q <= tape_mem[rd_ptr_q[TAPE_AW-1:0]];
   end

   assign tape_ready    = (state_q != ST_EMPTY);
   assign loader_active = state_q[1];
   assign ram_we        = pend_q & (state_q == ST_COPY) & ~dl_rise;
   assign ram_a         = ram_a_q;
   assign ram_din       = pend_q ? rd_data_q : 8'h00;
   assign patch_ofs     = addr - hook_addr;

   // Patch loop: XOR A / NOP|SCF / JR NC,-3 / JP target
   always_comb begin
      patch_dout = 8'hFF;
      if (loader_active && (patch_ofs < 16'd7)) begin
         case (patch_ofs[2:0])
            3'd0:    patch_dout = 8'hAF;
            3'd1:    patch_dout = (state_q == ST_DONE) ? 8'h37 : 8'h00;
            3'd2:    patch_dout = 8'h30;
            3'd3:    patch_dout = 8'hFD;
            3'd4:    patch_dout = 8'hC3;
            3'd5:    patch_dout = zx81 ? 8'h07 : 8'h03;
            3'd6:    patch_dout = 8'h02;
            default: patch_dout = 8'hFF;
         endcase
      end
   end

`ifdef TAPE_SUM_EN
   logic [7:0] sum_q;

   // Running sum of bytes written to RAM, restarted on each LOAD entry
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         sum_q <= 8'h00;
      end else if ((state_q == ST_READY) && (state_d == ST_COPY)) begin
         sum_q <= 8'h00;
      end else if (ram_we) begin
         sum_q <= sum_q + ram_din;
      end
   end

   assign tape_sum = sum_q;
`else
   assign tape_sum = 8'h00;
`endif

endmodule
